// File: rtl/fpadd_issue_ctrl_if.sv
// rtl/fpadd_issue_ctrl_if.sv - signal bundle between operand feeder, fpadd_issue_ctrl, fpadd adder and result consumer
// slave modport  : the controller side (takes operands/adder results, drives adder and result port)
// master modport : the environment side (feeder, adder, consumer)
interface fpadd_issue_ctrl_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // operand input port
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_a;
  logic [31:0]   in_b;

  // result output port
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_sum;
  logic          out_timeout;

  // adder side
  logic          add_start;
  logic [31:0]   add_a;
  logic [31:0]   add_b;
  logic [31:0]   add_sum;
  logic          add_done;

  // status
  logic          busy;
  logic [CW-1:0] count;

  modport slave (
    input  in_valid, in_a, in_b, out_ready, add_sum, add_done,
    output in_ready, out_valid, out_sum, out_timeout,
           add_start, add_a, add_b, busy, count
  );

  modport master (
    output in_valid, in_a, in_b, out_ready, add_sum, add_done,
    input  in_ready, out_valid, out_sum, out_timeout,
           add_start, add_a, add_b, busy, count
  );
endinterface

// File: rtl/fpadd_issue_ctrl.sv
// rtl/fpadd_issue_ctrl.sv - operand FIFO, one-at-a-time issue to fpadd, watchdog and result hold
// clk, reset : rising-edge clock, synchronous active-high reset
// bus.in_*   : operand pair valid/ready input, buffered in a DEPTH-entry FIFO
// bus.add_*  : start pulse and held operands to the adder, sticky done and sum back
// bus.out_*  : result valid/ready output; out_timeout marks a watchdog qNaN result
// bus.busy, bus.count : controller not idle, FIFO occupancy
module fpadd_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  fpadd_issue_ctrl_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [2:0] {IDLE, ISSUE, CLEAR, WAIT, HOLD} state_t;

  state_t        state_q, state_d;
  logic [31:0]   mem_a_q [DEPTH];
  logic [31:0]   mem_b_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [31:0]   add_a_q, add_a_d;
  logic [31:0]   add_b_q, add_b_d;
  logic [31:0]   out_sum_q, out_sum_d;
  logic          out_timeout_q, out_timeout_d;
  logic          push;
  logic          pop;

  // in_ready depends on the registered count only, so a pop never opens a
  // slot for a push in the same cycle.
  assign bus.in_ready = (count_q != CW'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d       = state_q;
    wd_d          = wd_q;
    out_sum_d     = out_sum_q;
    out_timeout_d = out_timeout_q;
    pop           = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = CLEAR;
      // The adder still shows the previous op's done here; it is ignored.
      CLEAR: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.add_done) begin
          out_sum_d     = bus.add_sum;
          out_timeout_d = 1'b0;
          state_d       = HOLD;
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
          out_sum_d     = QNAN;
          out_timeout_d = 1'b1;
          state_d       = HOLD;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    add_a_d  = pop ? mem_a_q[rd_ptr_q] : add_a_q;
    add_b_d  = pop ? mem_b_q[rd_ptr_q] : add_b_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage needs no reset: entries are only read below the count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= bus.in_a;
      mem_b_q[wr_ptr_q] <= bus.in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      wd_q          <= '0;
      add_a_q       <= '0;
      add_b_q       <= '0;
      out_sum_q     <= '0;
      out_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      wd_q          <= wd_d;
      add_a_q       <= add_a_d;
      add_b_q       <= add_b_d;
      out_sum_q     <= out_sum_d;
      out_timeout_q <= out_timeout_d;
    end
  end

  assign bus.add_start   = (state_q == ISSUE);
  assign bus.add_a       = add_a_q;
  assign bus.add_b       = add_b_q;
  assign bus.out_valid   = (state_q == HOLD);
  assign bus.out_sum     = out_sum_q;
  assign bus.out_timeout = out_timeout_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.count       = count_q;
endmodule

// File: tb/tb_fpadd_issue_ctrl.sv
// tb/tb_fpadd_issue_ctrl.sv - directed bench for fpadd_issue_ctrl with a behavioural sticky-done adder
module tb_fpadd_issue_ctrl;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam int LAT     = 6;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  fpadd_issue_ctrl_if #(.DEPTH(DEPTH)) bus ();

  fpadd_issue_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic        in_valid  = 1'b0;
  logic [31:0] in_a      = '0;
  logic [31:0] in_b      = '0;
  logic        out_ready = 1'b0;
  logic        m_done    = 1'b0;
  logic [31:0] m_out     = '0;

  assign bus.in_valid  = in_valid;
  assign bus.in_a      = in_a;
  assign bus.in_b      = in_b;
  assign bus.out_ready = out_ready;
  assign bus.add_done  = m_done;
  assign bus.add_sum   = m_out;

  // Known IEEE-754 sums for the operand pairs used below.
  function automatic logic [31:0] fp_add_model(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000;
      {32'h40A00000, 32'hBF800000}: return 32'h40800000;
      {32'h40400000, 32'h40400000}: return 32'h40C00000;
      {32'h3F000000, 32'h3F000000}: return 32'h3F800000;
      {32'h41200000, 32'h40A00000}: return 32'h41700000;
      {32'hBF800000, 32'h3F800000}: return 32'h00000000;
      {32'h40000000, 32'h40000000}: return 32'h40800000;
      default:                      return 32'hDEADBEEF;
    endcase
  endfunction

  // Behavioural adder: done visible LAT+1 cycles after the start cycle, sticky.
  logic        stale_mode = 1'b0;
  logic        never_done = 1'b0;
  logic [31:0] m_sum      = '0;
  int          m_cnt      = 0;
  logic        m_busy     = 1'b0;
  logic        m_drop     = 1'b0;

  always @(posedge clk) begin
    if (bus.add_start) begin
      m_sum  <= fp_add_model(bus.add_a, bus.add_b);
      m_cnt  <= LAT;
      m_busy <= !never_done;
      if (stale_mode) m_drop <= 1'b1;
      else            m_done <= 1'b0;
    end else begin
      if (m_drop) begin
        m_done <= 1'b0;
        m_drop <= 1'b0;
      end
      if (m_busy) begin
        if (m_cnt == 1) begin
          m_done <= 1'b1;
          m_out  <= m_sum;
          m_busy <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  int   start_q[$];
  int   last_start = -1;
  logic prev_start = 1'b0;

  always @(negedge clk) begin
    if (bus.add_start) begin
      checks++;
      if (prev_start) begin
        errors++;
        $display("FAIL single_start: add_start high in consecutive cycles at cycle %0d, required one-cycle pulse", cyc);
      end
      start_q.push_back(cyc);
      last_start = cyc;
    end
    prev_start = bus.add_start;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, output int acc);
    int t;
    t        = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    while (!bus.in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    acc = cyc;
    if (t >= 500) begin
      checks++;
      errors++;
      $display("FAIL push_wait: in_ready stayed 0 for %0d cycles, required 1", t);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string nm, output int t_ov);
    int t;
    t = 0;
    while (!bus.out_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    t_ov = cyc;
    if (!bus.out_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_wait: out_valid 0 after %0d cycles, required 1", nm, t);
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  vec_t vecs[5];
  vec_t fill[6];
  int   n, tov, s0, dummy, got, t, ov_seen;

  initial begin
    vecs[0] = '{32'h40A00000, 32'hBF800000, 32'h40800000};
    vecs[1] = '{32'h40000000, 32'h40000000, 32'h40800000};
    vecs[2] = '{32'h3F000000, 32'h3F000000, 32'h3F800000};
    vecs[3] = '{32'h41200000, 32'h40A00000, 32'h41700000};
    vecs[4] = '{32'hBF800000, 32'h3F800000, 32'h00000000};

    fill[0] = '{32'h3F800000, 32'h40000000, 32'h40400000};
    fill[1] = '{32'h40A00000, 32'hBF800000, 32'h40800000};
    fill[2] = '{32'h40400000, 32'h40400000, 32'h40C00000};
    fill[3] = '{32'h3F000000, 32'h3F000000, 32'h3F800000};
    fill[4] = '{32'h41200000, 32'h40A00000, 32'h41700000};
    fill[5] = '{32'hBF800000, 32'h3F800000, 32'h00000000};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_in_ready",    32'(bus.in_ready),    32'd1);
    chk("rst_out_valid",   32'(bus.out_valid),   32'd0);
    chk("rst_out_sum",     bus.out_sum,          32'd0);
    chk("rst_out_timeout", 32'(bus.out_timeout), 32'd0);
    chk("rst_add_start",   32'(bus.add_start),   32'd0);
    chk("rst_add_a",       bus.add_a,            32'd0);
    chk("rst_add_b",       bus.add_b,            32'd0);
    chk("rst_busy",        32'(bus.busy),        32'd0);
    chk("rst_count",       32'(bus.count),       32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single op with latency from an empty FIFO
    s0 = start_q.size();
    push(32'h3F800000, 32'h40000000, n);
    wait_valid("single", tov);
    chk("single_start_lat",   32'(last_start - n),        32'd2);
    chk("single_valid_lat",   32'(tov - n),               32'(LAT + 4));
    chk("single_start_count", 32'(start_q.size() - s0),   32'd1);
    chk("single_sum",         bus.out_sum,                32'h40400000);
    chk("single_timeout",     32'(bus.out_timeout),       32'd0);
    accept();

    // Table-driven single operations
    for (int i = 0; i < 5; i++) begin
      push(vecs[i].a, vecs[i].b, n);
      wait_valid($sformatf("vec%0d", i), tov);
      chk($sformatf("vec%0d_sum", i),     bus.out_sum,              vecs[i].sum);
      chk($sformatf("vec%0d_timeout", i), 32'(bus.out_timeout),     32'd0);
      chk($sformatf("vec%0d_lat", i),     32'(tov - last_start),    32'(LAT + 2));
      chk($sformatf("vec%0d_add_a", i),   bus.add_a,                vecs[i].a);
      chk($sformatf("vec%0d_add_b", i),   bus.add_b,                vecs[i].b);
      accept();
    end

    // Fill with backpressure, then drain back-to-back
    s0 = start_q.size();
    fork
      begin
        for (int i = 0; i < 6; i++) push(fill[i].a, fill[i].b, dummy);
      end
      begin
        repeat (30) @(negedge clk);
        chk("full_count",     32'(bus.count),     32'(DEPTH));
        chk("full_in_ready",  32'(bus.in_ready),  32'd0);
        chk("full_out_valid", 32'(bus.out_valid), 32'd1);
        chk("full_first_sum", bus.out_sum,        fill[0].sum);
        out_ready = 1'b1;
        #1;
        chk("full_pop_in_ready", 32'(bus.in_ready), 32'd0);
        got = 0;
        t   = 0;
        while (got < 6 && t < 400) begin
          if (bus.out_valid) begin
            chk($sformatf("fill%0d_sum", got), bus.out_sum, fill[got].sum);
            got++;
          end
          @(negedge clk);
          t++;
        end
        chk("fill_results", 32'(got), 32'd6);
      end
    join
    out_ready = 1'b0;
    chk("fill_start_count", 32'(start_q.size() - s0), 32'd6);
    for (int k = 2; k < 6; k++) begin
      if (start_q.size() > s0 + k)
        chk($sformatf("b2b_spacing%0d", k), 32'(start_q[s0 + k] - start_q[s0 + k - 1]), 32'(LAT + 3));
    end

    // Stale done from the previous op held through ISSUE and CLEAR
    stale_mode = 1'b1;
    push(32'h41200000, 32'h40A00000, n);
    wait_valid("stale", tov);
    chk("stale_sum",     bus.out_sum,           32'h41700000);
    chk("stale_timeout", 32'(bus.out_timeout),  32'd0);
    chk("stale_lat",     32'(tov - last_start), 32'(LAT + 2));
    accept();
    stale_mode = 1'b0;

    // Watchdog, then the queued pair issues normally
    never_done = 1'b1;
    push(32'h40400000, 32'h40400000, n);
    push(32'h3F000000, 32'h3F000000, n);
    wait_valid("wdog", tov);
    chk("wdog_sum",     bus.out_sum,           32'h7FC00000);
    chk("wdog_timeout", 32'(bus.out_timeout),  32'd1);
    chk("wdog_lat",     32'(tov - last_start), 32'(TIMEOUT + 2));
    never_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("wdog_hold_valid",   32'(bus.out_valid),   32'd1);
    chk("wdog_hold_sum",     bus.out_sum,          32'h7FC00000);
    chk("wdog_hold_timeout", 32'(bus.out_timeout), 32'd1);
    accept();
    wait_valid("wdog_next", tov);
    chk("wdog_next_sum",     bus.out_sum,           32'h3F800000);
    chk("wdog_next_timeout", 32'(bus.out_timeout),  32'd0);
    chk("wdog_next_lat",     32'(tov - last_start), 32'(LAT + 2));
    accept();

    // Reset pulse mid-WAIT with a pair still queued
    push(32'h40A00000, 32'hBF800000, n);
    push(32'h40400000, 32'h40400000, n);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_count",     32'(bus.count),     32'd0);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_busy",      32'(bus.busy),      32'd0);
    chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    s0      = start_q.size();
    ov_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid) ov_seen++;
    end
    chk("mid_rst_no_output", 32'(ov_seen), 32'd0);
    chk("mid_rst_no_start",  32'(start_q.size() - s0), 32'd0);
    push(32'h3F800000, 32'h40000000, n);
    wait_valid("post_rst", tov);
    chk("post_rst_sum",     bus.out_sum,           32'h40400000);
    chk("post_rst_timeout", 32'(bus.out_timeout),  32'd0);
    chk("post_rst_lat",     32'(tov - n),          32'(LAT + 4));
    accept();

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete in time");
    $fatal(1, "bench time limit reached");
  end
endmodule
